// File: rtl/alu.sv
// alu - registered 64-bit lane-wise vector ALU for the execute stage.
//
// One R-type vector operation (selected by R_ins) is applied across two
// 64-bit operands split into 8/16/32/64-bit lanes (selected by WW). The
// result is captured in ALU_out on the next rising clk edge.
//
// Ports
//   clk          in   1     clock, rising edge
//   rst_n        in   1     asynchronous active-low reset, clears ALU_out
//   rA_64bit_val in   [0:63] operand A (bit 0 = MSB)
//   rB_64bit_val in   [0:63] operand B (bit 0 = MSB)
//   R_ins        in   [0:5]  function code
//   Op_code      in   [0:5]  primary opcode, only 6'b101010 executes
//   WW           in   [0:1]  lane width 00=8b 01=16b 10=32b 11=64b
//   ALU_out      out  [0:63] registered result
//
// Big-endian lane numbering: lane 0 is the most significant lane. Internally
// operands are held as [63:0] vectors with the same numeric value, so lane 0
// sits at the top. Within a 2w-bit pair, the even lane is the upper half and
// the odd lane the lower half, which is exactly where a widening product of
// that pair lands.

module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:63] rA_64bit_val,
  input  logic [0:63] rB_64bit_val,
  input  logic [0:5]  R_ins,
  input  logic [0:5]  Op_code,
  input  logic [0:1]  WW,
  output logic [0:63] ALU_out
);

  localparam logic [5:0] OP_RVEC  = 6'b101010;

  localparam logic [5:0] F_VAND   = 6'b000001;
  localparam logic [5:0] F_VOR    = 6'b000010;
  localparam logic [5:0] F_VXOR   = 6'b000011;
  localparam logic [5:0] F_VNOT   = 6'b000100;
  localparam logic [5:0] F_VMOV   = 6'b000101;
  localparam logic [5:0] F_VADD   = 6'b000110;
  localparam logic [5:0] F_VSUB   = 6'b000111;
  localparam logic [5:0] F_VMULEU = 6'b001000;
  localparam logic [5:0] F_VMULOU = 6'b001001;
  localparam logic [5:0] F_VSLL   = 6'b001010;
  localparam logic [5:0] F_VSRL   = 6'b001011;
  localparam logic [5:0] F_VSRA   = 6'b001100;
  localparam logic [5:0] F_VRTTH  = 6'b001101;
  localparam logic [5:0] F_VDIV   = 6'b001110;
  localparam logic [5:0] F_VMOD   = 6'b001111;
  localparam logic [5:0] F_VSQEU  = 6'b010000;
  localparam logic [5:0] F_VSQOU  = 6'b010001;
  localparam logic [5:0] F_VSQRT  = 6'b010010;

  // Value-preserving conversion from the big-endian port ranges.
  logic [63:0] a;
  logic [63:0] b;
  logic [5:0]  fn;
  logic [5:0]  opc;
  logic [1:0]  ww;

  assign a   = rA_64bit_val;
  assign b   = rB_64bit_val;
  assign fn  = R_ins;
  assign opc = Op_code;
  assign ww  = WW;

  // Bit-serial integer square root, floor(sqrt(v)).
  function automatic logic [63:0] isqrt(input logic [63:0] v);
    logic [63:0] x;
    logic [63:0] r;
    logic [63:0] bv;
    x  = v;
    r  = '0;
    bv = 64'h4000_0000_0000_0000;
    for (int i = 0; i < 32; i++) begin
      if (x >= r + bv) begin
        x = x - (r + bv);
        r = (r >> 1) + bv;
      end else begin
        r = r >> 1;
      end
      bv = bv >> 2;
    end
    return r;
  endfunction

  // Non-widening lane op on zero-extended lane values. lw selects the lane
  // width (0:8, 1:16, 2:32, 3:64); results are masked to the lane.
  function automatic logic [63:0] lane_op(input logic [5:0]  f,
                                          input logic [63:0] la,
                                          input logic [63:0] lb,
                                          input logic [1:0]  lw);
    logic [6:0]  w;
    logic [6:0]  half;
    logic [63:0] mask;
    logic [5:0]  sh;
    logic [63:0] sx;
    logic [63:0] r;
    w    = 7'd8 << lw;
    half = w >> 1;
    mask = (lw == 2'b11) ? '1 : ((64'd1 << w) - 64'd1);
    // Shift amount is the log2(w) LSBs of the B lane; w=64 wraps the mask to 63.
    sh   = lb[5:0] & (w[5:0] - 6'd1);
    sx   = la | ({64{la[w - 7'd1]}} & ~mask);
    case (f)
      F_VADD:  r = la + lb;
      F_VSUB:  r = la - lb;
      F_VSLL:  r = la << sh;
      F_VSRL:  r = la >> sh;
      F_VSRA:  r = 64'($signed(sx) >>> sh);
      F_VRTTH: r = (la << half) | (la >> half);
      F_VDIV:  r = (lb == '0) ? mask : la / lb;
      F_VMOD:  r = (lb == '0) ? la : la % lb;
      F_VSQRT: r = isqrt(la);
      default: r = '0;
    endcase
    return r & mask;
  endfunction

  // Widening lane-pair op; hi is the even lane, lo the odd lane of a pair.
  function automatic logic [63:0] wide_op(input logic [5:0]  f,
                                          input logic [63:0] a_hi,
                                          input logic [63:0] a_lo,
                                          input logic [63:0] b_hi,
                                          input logic [63:0] b_lo);
    logic [63:0] r;
    case (f)
      F_VMULEU: r = a_hi * b_hi;
      F_VMULOU: r = a_lo * b_lo;
      F_VSQEU:  r = a_hi * a_hi;
      F_VSQOU:  r = a_lo * a_lo;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [63:0] res8;
  logic [63:0] res16;
  logic [63:0] res32;
  logic [63:0] res64;
  logic [63:0] wide8;
  logic [63:0] wide16;
  logic [63:0] wide32;

  always_comb begin
    res8 = '0;
    for (int i = 0; i < 8; i++) begin
      res8[i*8 +: 8] = 8'(lane_op(fn, {56'd0, a[i*8 +: 8]},
                                      {56'd0, b[i*8 +: 8]}, 2'd0));
    end
  end

  always_comb begin
    res16 = '0;
    for (int i = 0; i < 4; i++) begin
      res16[i*16 +: 16] = 16'(lane_op(fn, {48'd0, a[i*16 +: 16]},
                                          {48'd0, b[i*16 +: 16]}, 2'd1));
    end
  end

  always_comb begin
    res32 = '0;
    for (int i = 0; i < 2; i++) begin
      res32[i*32 +: 32] = 32'(lane_op(fn, {32'd0, a[i*32 +: 32]},
                                          {32'd0, b[i*32 +: 32]}, 2'd2));
    end
  end

  assign res64 = lane_op(fn, a, b, 2'd3);

  always_comb begin
    wide8 = '0;
    for (int p = 0; p < 4; p++) begin
      wide8[p*16 +: 16] = 16'(wide_op(fn,
                                      {56'd0, a[p*16 + 8 +: 8]}, {56'd0, a[p*16 +: 8]},
                                      {56'd0, b[p*16 + 8 +: 8]}, {56'd0, b[p*16 +: 8]}));
    end
  end

  always_comb begin
    wide16 = '0;
    for (int p = 0; p < 2; p++) begin
      wide16[p*32 +: 32] = 32'(wide_op(fn,
                                       {48'd0, a[p*32 + 16 +: 16]}, {48'd0, a[p*32 +: 16]},
                                       {48'd0, b[p*32 + 16 +: 16]}, {48'd0, b[p*32 +: 16]}));
    end
  end

  assign wide32 = wide_op(fn, {32'd0, a[63:32]}, {32'd0, a[31:0]},
                              {32'd0, b[63:32]}, {32'd0, b[31:0]});

  logic [63:0] lane_sel;
  logic [63:0] wide_sel;

  always_comb begin
    case (ww)
      2'b00:   lane_sel = res8;
      2'b01:   lane_sel = res16;
      2'b10:   lane_sel = res32;
      default: lane_sel = res64;
    endcase
  end

  // A 64-bit lane has no partner lane to widen into, so the result is 0.
  always_comb begin
    case (ww)
      2'b00:   wide_sel = wide8;
      2'b01:   wide_sel = wide16;
      2'b10:   wide_sel = wide32;
      default: wide_sel = '0;
    endcase
  end

  logic [63:0] next_out;

  always_comb begin
    next_out = '0;
    if (opc == OP_RVEC) begin
      case (fn)
        F_VAND:   next_out = a & b;
        F_VOR:    next_out = a | b;
        F_VXOR:   next_out = a ^ b;
        F_VNOT:   next_out = ~a;
        F_VMOV:   next_out = a;
        F_VADD, F_VSUB, F_VSLL, F_VSRL, F_VSRA,
        F_VRTTH, F_VDIV, F_VMOD, F_VSQRT:
                  next_out = lane_sel;
        F_VMULEU, F_VMULOU, F_VSQEU, F_VSQOU:
                  next_out = wide_sel;
        default:  next_out = '0;
      endcase
    end
  end

  logic [63:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= next_out;
    end
  end

  assign ALU_out = out_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [0:63] rA_64bit_val;
  logic [0:63] rB_64bit_val;
  logic [0:5]  R_ins;
  logic [0:5]  Op_code;
  logic [0:1]  WW;
  logic [0:63] ALU_out;

  int n_checks = 0;
  int n_errors = 0;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val),
    .R_ins        (R_ins),
    .Op_code      (Op_code),
    .WW           (WW),
    .ALU_out      (ALU_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  localparam logic [5:0] RV = 6'b101010;

  // Drive a vector just after an edge, capture on the next edge, sample 1 after.
  task automatic run(input string tag, input logic [5:0] fn, input logic [1:0] w,
                     input logic [63:0] av, input logic [63:0] bv, input logic [63:0] exp);
    Op_code      = RV;
    R_ins        = fn;
    WW           = w;
    rA_64bit_val = av;
    rB_64bit_val = bv;
    @(posedge clk);
    #1;
    chk(tag, ALU_out, exp);
  endtask

  initial begin
    rst_n        = 1'b0;
    Op_code      = RV;
    R_ins        = 6'b000101;
    WW           = 2'b00;
    rA_64bit_val = 64'hDEAD_BEEF_0000_0001;
    rB_64bit_val = '0;
    #1;
    chk("reset_async", ALU_out, 64'h0);
    @(posedge clk);
    #1;
    chk("reset_held", ALU_out, 64'h0);
    #2 rst_n = 1'b1;
    #1;
    chk("reset_release_no_edge", ALU_out, 64'h0);
    @(posedge clk);
    #1;
    chk("first_capture", ALU_out, 64'hDEAD_BEEF_0000_0001);

    run("vand",   6'b000001, 2'b00, 64'd15, 64'd14, 64'd14);
    run("vor",    6'b000010, 2'b00, 64'd15, 64'd14, 64'd15);
    run("vxor",   6'b000011, 2'b00, 64'd15, 64'd14, 64'd1);
    run("vnot",   6'b000100, 2'b01, 64'd0,  64'd5,  64'hFFFF_FFFF_FFFF_FFFF);
    run("vmov",   6'b000101, 2'b00, 64'hFFFF_FFFF_0000_0000, 64'd7, 64'hFFFF_FFFF_0000_0000);

    run("vadd_w32", 6'b000110, 2'b10, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_1111_1111,
        64'hFFFF_FFFF_1111_1111);
    run("vadd_w8",  6'b000110, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1111_1111,
        64'hFFFF_FFFF_1010_1010);
    run("vsub_w32", 6'b000111, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_1111_1111,
        64'hF0F0_F0F0_EEEE_EEEE);
    run("vsub_w64_wrap", 6'b000111, 2'b11, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);

    run("vmuleu_w16", 6'b001000, 2'b01, 64'hFF00_0000_FFFF_FFFF, 64'h0002_0000_000F_0001,
        64'h0001_FE00_000E_FFF1);
    run("vmulou_w32", 6'b001001, 2'b10, 64'd20, 64'd20, 64'd400);
    run("vmuleu_w32", 6'b001000, 2'b10, 64'd20, 64'd20, 64'd0);
    run("vmuleu_w64", 6'b001000, 2'b11, 64'd20, 64'd20, 64'd0);
    run("vmulou_w8",  6'b001001, 2'b00, 64'h0003_0000_0000_00FF, 64'h0005_0000_0000_00FF,
        64'h000F_0000_0000_FE01);

    run("vsll_w16", 6'b001010, 2'b01, 64'h0001_0001_0001_0001, 64'h0000_0001_000F_0010,
        64'h0001_0002_8000_0001);
    run("vsrl_w8",  6'b001011, 2'b00, 64'h8080_8080_8080_8080, 64'h0102_0304_0708_0900,
        64'h4020_1008_0180_4080);
    run("vsra_w8",  6'b001100, 2'b00, 64'h8080_8080_8080_8080, 64'h0102_0304_0708_0900,
        64'hC0E0_F0F8_FF80_C080);

    run("vrtth_w64", 6'b001101, 2'b11, 64'hFFFF_FFFF_0000_0000, 64'd0, 64'h0000_0000_FFFF_FFFF);
    run("vrtth_w8",  6'b001101, 2'b00, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h2143_6587_A9CB_ED0F);

    run("vdiv_w8",  6'b001110, 2'b00, 64'hFF00_FF00_FF00_FF00, 64'h1122_1122_4444_4444,
        64'h0F00_0F00_0300_0300);
    run("vmod_w64", 6'b001111, 2'b11, 64'd102, 64'd10, 64'd2);
    run("vdiv_zero_w8", 6'b001110, 2'b00, 64'h1020_3040_5060_7080, 64'h0200_0400_0500_0800,
        64'h08FF_0CFF_10FF_0EFF);
    run("vmod_zero_w8", 6'b001111, 2'b00, 64'h1020_3040_5060_7080, 64'h0200_0400_0500_0800,
        64'h0020_0040_0060_0080);
    run("vdiv_zero_w64", 6'b001110, 2'b11, 64'd77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);

    run("vsqeu_w32", 6'b010000, 2'b10, 64'h0000_0040_0000_0001, 64'd0, 64'h0000_0000_0000_1000);
    run("vsqou_w32", 6'b010001, 2'b10, 64'h0000_0040_0000_0001, 64'd0, 64'h0000_0000_0000_0001);
    run("vsqrt_w32", 6'b010010, 2'b10, 64'h0000_0040_0000_0010, 64'd0, 64'h0000_0008_0000_0004);
    run("vsqrt_w8",  6'b010010, 2'b00, 64'hFF00_0102_0304_0951, 64'd0, 64'h0F00_0101_0102_0309);

    run("unlisted_fn", 6'b111111, 2'b00, 64'hFFFF, 64'hFFFF, 64'd0);
    Op_code      = 6'b000000;
    R_ins        = 6'b000101;
    rA_64bit_val = 64'h1234;
    @(posedge clk);
    #1;
    chk("bad_opcode", ALU_out, 64'd0);

    // Output holds while inputs change between edges.
    run("hold_setup", 6'b000101, 2'b00, 64'hA5A5_A5A5_5A5A_5A5A, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A);
    rA_64bit_val = 64'h1111;
    #3;
    chk("hold_between_edges", ALU_out, 64'hA5A5_A5A5_5A5A_5A5A);

    // Mid-stream reset between edges.
    rst_n = 1'b0;
    #1;
    chk("reset_mid_async", ALU_out, 64'd0);
    @(posedge clk);
    #1;
    chk("reset_mid_held", ALU_out, 64'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("reset_mid_release", ALU_out, 64'd0);
    @(posedge clk);
    #1;
    chk("after_reset_capture", ALU_out, 64'h1111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
